// File: rtl/echo_initiator_pkg.sv
// ---------------------------------------------------------------------------
// echo_initiator_pkg: state encoding and error-counter limit for the echo loop
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package echo_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == ERR_MAX) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/echo_timer.sv
// ---------------------------------------------------------------------------
// echo_timer: counts response-wait cycles and flags the last allowed cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module echo_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/echo_initiator.sv
// ---------------------------------------------------------------------------
// echo_initiator: sends one word, waits for its echo and checks it
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module echo_initiator
  import echo_initiator_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             req_valid,
  output logic [WIDTH-1:0] req_data,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             timeout,
  output logic [7:0]       err_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] req_word;
  logic [WIDTH-1:0] rsp_word;
  logic             match_held;
  logic [7:0]       errs;
  logic             expired;
  logic             accept;
  logic             got_rsp;
  logic             expire_now;
  logic             same;
  logic             err_inc;

  assign accept     = (state == ST_IDLE) && start;
  assign got_rsp    = (state == ST_WAIT) && rsp_valid;
  // A response on the last wait cycle takes priority over the timeout.
  assign expire_now = (state == ST_WAIT) && !rsp_valid && expired;
  assign same       = (rsp_word == req_word);
  assign err_inc    = expire_now || ((state == ST_CHECK) && !same);

  echo_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_WAIT),
    .enable  ((state == ST_WAIT) && !rsp_valid && !expired),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SEND;
      ST_SEND:  state_nxt = ST_WAIT;
      ST_WAIT:  if (rsp_valid || expired) state_nxt = rsp_valid ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_word   <= '0;
      rsp_word   <= '0;
      match_held <= 1'b0;
      errs       <= 8'd0;
    end else begin
      if (accept) begin
        req_word   <= data_in;
        match_held <= 1'b0;
      end
      if (got_rsp) begin
        rsp_word <= rsp_data;
      end
      if (state == ST_CHECK) begin
        match_held <= same;
      end
      if (err_inc) begin
        errs <= sat_inc(errs);
      end
    end
  end

  assign req_valid = (state == ST_SEND);
  assign req_data  = req_word;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_CHECK);
  assign match     = (state == ST_CHECK) ? same : match_held;
  assign timeout   = expire_now;
  assign err_count = errs;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0({done, timeout, req_valid}));
      assert (busy || (!done && !req_valid));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_echo_initiator.sv
// ---------------------------------------------------------------------------
// tb_echo_initiator: directed bench with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_echo_initiator;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             rsp_valid = 1'b0;
  logic [WIDTH-1:0] rsp_data = '0;
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             busy;
  logic             done;
  logic             match;
  logic             timeout;
  logic [7:0]       err_count;

  int errors = 0;
  int checks = 0;

  echo_initiator #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .req_valid (req_valid),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .timeout   (timeout),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Echo responder: answers resp_delay cycles after req_valid (0 = silent).
  int         resp_delay = 1;
  logic [7:0] resp_mask = '0;
  int         rcnt = 0;
  logic [7:0] rword = '0;

  always @(posedge clk) begin
    #1;
    rsp_valid = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = rword;
      end
    end
    if (req_valid === 1'b1 && resp_delay > 0) begin
      rcnt  = resp_delay;
      rword = req_data ^ resp_mask;
    end
  end

  // Reference model: a transaction accepted in cycle t0 sends at t0+1, listens
  // for an echo in t0+2 .. t0+1+TIMEOUT, and ends one cycle after the echo or
  // on the last listening cycle.
  int         cyc = 0;
  int         t0 = 0;
  int         ra = 0;
  bit         armed = 1'b0;
  bit         m_active = 1'b0;
  bit         m_got = 1'b0;
  logic [7:0] m_req = '0;
  logic [7:0] m_rsp = '0;
  logic [7:0] m_errs = '0;
  logic       m_match = 1'b0;

  always @(posedge clk) begin
    int e;
    int age;
    e   = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      armed    = 1'b1;
      m_active = 1'b0;
      m_got    = 1'b0;
      m_req    = '0;
      m_match  = 1'b0;
      m_errs   = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_got    = 1'b0;
        t0       = e;
        m_req    = data_in;
        m_match  = 1'b0;
      end
    end else begin
      age = e - t0;
      if (!m_got && age >= 2 && age <= TIMEOUT + 1 && rsp_valid) begin
        m_got = 1'b1;
        ra    = age;
        m_rsp = rsp_data;
      end
      if (m_got && age == ra + 1) begin
        m_active = 1'b0;
        m_match  = (m_rsp == m_req);
        if (!m_match) m_errs = (m_errs == 8'd255) ? m_errs : m_errs + 8'd1;
      end else if (!m_got && age == TIMEOUT + 1) begin
        m_active = 1'b0;
        m_errs   = (m_errs == 8'd255) ? m_errs : m_errs + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    int         age;
    logic       e_rv;
    logic       e_done;
    logic       e_to;
    logic       e_match;
    logic [24:0] act;
    logic [24:0] exp;
    if (armed) begin
      age     = cyc - t0;
      e_rv    = m_active && age == 1;
      e_done  = m_active && m_got && age == ra + 1;
      e_to    = m_active && !m_got && age == TIMEOUT + 1 && !rsp_valid;
      e_match = e_done ? (m_rsp == m_req) : m_match;
      act = {busy, req_valid, done, timeout, match, req_data, err_count, 4'h0};
      exp = {m_active, e_rv, e_done, e_to, e_match, m_req, m_errs, 4'h0};
      checks++;
      if (act !== exp) begin
        errors++;
        if (errors < 40)
          $display("FAIL model cycle %0d: got %h expected %h (busy,rv,done,to,match,req,err)",
                   cyc, act, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_data", 32'(req_data), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset match", 32'(match), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic echo
    resp_delay = 1; resp_mask = 8'h00;
    start = 1'b1; data_in = 8'hA5;
    tick();
    start = 1'b0;
    check("t1 req_valid c1", 32'(req_valid), 32'd1);
    check("t1 req_data c1", 32'(req_data), 32'hA5);
    tick();
    check("t1 done c2", 32'(done), 32'd0);
    tick();
    check("t1 done c3", 32'(done), 32'd1);
    check("t1 match c3", 32'(match), 32'd1);
    check("t1 err c3", 32'(err_count), 32'd0);
    tick();
    check("t1 busy c4", 32'(busy), 32'd0);
    check("t1 match held", 32'(match), 32'd1);

    // Mismatch
    resp_mask = 8'h01;
    start = 1'b1; data_in = 8'h3C;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t2 done", 32'(done), 32'd1);
    check("t2 match", 32'(match), 32'd0);
    tick();
    check("t2 err", 32'(err_count), 32'd1);

    // Timeout with a silent responder
    resp_delay = 0; resp_mask = 8'h00;
    start = 1'b1; data_in = 8'h5A;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("t3 timeout c15", 32'(timeout), 32'd0);
    tick();
    check("t3 timeout c16", 32'(timeout), 32'd1);
    check("t3 busy c16", 32'(busy), 32'd1);
    tick();
    check("t3 busy c17", 32'(busy), 32'd0);
    check("t3 err", 32'(err_count), 32'd2);

    // Response on the final wait cycle wins
    resp_delay = 15;
    start = 1'b1; data_in = 8'hC3;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("t4a timeout c16", 32'(timeout), 32'd0);
    tick();
    check("t4a done c17", 32'(done), 32'd1);
    check("t4a err", 32'(err_count), 32'd2);
    tick();

    // Response one cycle too late: timeout, stray echo ignored
    resp_delay = 16;
    start = 1'b1; data_in = 8'h96;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("t4b timeout c16", 32'(timeout), 32'd1);
    tick();
    check("t4b done c17", 32'(done), 32'd0);
    tick();
    check("t4b err", 32'(err_count), 32'd3);

    // Start while busy and start on the return to idle
    resp_delay = 1;
    start = 1'b1; data_in = 8'hA1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; data_in = 8'h77;
    tick();
    check("t5 done", 32'(done), 32'd1);
    check("t5 req_data", 32'(req_data), 32'hA1);
    tick();
    check("t5 busy idle", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("t5 second req", 32'(req_valid), 32'd1);
    check("t5 second data", 32'(req_data), 32'h77);
    repeat (3) tick();

    // Reset during WAIT
    resp_delay = 0;
    start = 1'b1; data_in = 8'h11;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 req_data", 32'(req_data), 32'd0);
    check("t6 err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Saturation
    resp_delay = 1; resp_mask = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      start = 1'b1; data_in = 8'(i);
      tick();
      start = 1'b0;
      repeat (3) tick();
    end
    check("t6 saturate", 32'(err_count), 32'd255);
    start = 1'b1; data_in = 8'h42;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t6 stay 255", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
